// File: rtl/clkreg_pkg.sv
// Shared widths and reset values for the multi-channel clock regulator.
package clkreg_pkg;

    localparam int unsigned CNT_W        = 26;
    localparam int unsigned DEFAULT_HALF = 50_000_000 / 2;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: programmable half-period counter with load/sync/enable priority.
module clk_div_channel
    import clkreg_pkg::*;
#(
    parameter cnt_t RST_HALF = cnt_t'(DEFAULT_HALF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync,
    input  logic load,
    input  cnt_t load_val,
    output logic clk_out,
    output logic tick
);

    cnt_t half;
    cnt_t cnt;

    // Load beats sync beats disable beats terminal count; cnt < half keeps the compare wrap-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half    <= RST_HALF;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                half <= load_val;
                cnt  <= '0;
            end else if (sync || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (cnt == half - cnt_t'(1)) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                cnt <= cnt + cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/clock_regulator_multi.sv
// N_CH independent programmable square-wave generators with toggle ticks,
// runtime half-period configuration and a global phase re-sync.
module clock_regulator_multi
    import clkreg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEFAULT_HALF = CLK_HZ / 2
) (
    input  logic                         C_50Mhz,
    input  logic                         rst_n,
    input  logic [N_CH-1:0]              enable,
    input  logic                         sync,
    input  logic                         cfg_we,
    input  logic [$clog2(N_CH+1)-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]             cfg_half,
    output logic                         cfg_err,
    output logic [N_CH-1:0]              clk_out,
    output logic [N_CH-1:0]              tick
);

    // Channel field is one value wider than needed so out-of-range targets are expressible.
    localparam int unsigned CH_W = $clog2(N_CH + 1);

    logic            cfg_ok_c;
    logic [N_CH-1:0] load_c;

    assign cfg_ok_c = cfg_we && (cfg_half != '0) && (cfg_ch < CH_W'(N_CH));

    always_ff @(posedge C_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok_c;
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        assign load_c[i] = cfg_ok_c && (cfg_ch == CH_W'(i));

        clk_div_channel #(
            .RST_HALF (cnt_t'(DEFAULT_HALF))
        ) u_ch (
            .clk      (C_50Mhz),
            .rst_n    (rst_n),
            .en       (enable[i]),
            .sync     (sync),
            .load     (load_c[i]),
            .load_val (cfg_half),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_regulator_multi.sv
// Directed bench for clock_regulator_multi with N_CH=4, DEFAULT_HALF=4.
module tb_clock_regulator_multi;

    localparam int unsigned N_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  enable;
    logic        sync;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [25:0] cfg_half;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int tests_run    = 0;
    int tests_failed = 0;

    clock_regulator_multi #(
        .N_CH         (N_CH),
        .DEFAULT_HALF (4)
    ) dut (
        .C_50Mhz  (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, released just after an edge so the following edge is edge 1.
    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 4'h0;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_half = 26'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_vec(input string name, input int edge_n,
                             input logic [3:0] exp_clk, input logic [3:0] exp_tick);
        tests_run++;
        if (clk_out !== exp_clk || tick !== exp_tick) begin
            tests_failed++;
            $display("FAIL %s edge %0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                     name, edge_n, clk_out, tick, exp_clk, exp_tick);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 4'hF;
        sync   = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = 3'd0;
        cfg_half = 26'd0;
        #3;
        tests_run++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: clk_out=%b tick=%b cfg_err=%b, expected 0000 0000 0",
                     clk_out, tick, cfg_err);
        end
        step();
        rst_n = 1'b1;
        // Half=4: rise at 4, fall at 8, rise at 12, tick on each.
        for (int e = 1; e <= 12; e++) begin
            step();
            check_vec("free_run", e, ((e / 4) % 2 == 1) ? 4'hF : 4'h0,
                      (e % 4 == 0) ? 4'hF : 4'h0);
        end
    endtask

    task automatic test_write_mid_period();
        logic [3:0] exp_c [9];
        logic [3:0] exp_t [9];
        exp_c = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b0010};
        exp_t = '{4'b1101, 4'b0010, 4'b0000, 4'b0010, 4'b1101, 4'b0010, 4'b0000, 4'b0010, 4'b1101};
        // Continues from test_reset: after edge 12 all high, cnt 0.
        step();
        step();
        cfg_we   = 1'b1;
        cfg_ch   = 3'd1;
        cfg_half = 26'd2;
        step();
        cfg_we = 1'b0;
        check_vec("write_edge", 15, 4'hF, 4'h0);
        tests_run++;
        if (cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_ok_err: cfg_err=%b, expected 0", cfg_err);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            check_vec("write_ch1_half2", 16 + k, exp_c[k], exp_t[k]);
        end
    endtask

    task automatic test_reject();
        logic [3:0] exp_err;
        exp_err = 4'b0101;
        do_reset();
        enable   = 4'hF;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd1;
        cfg_half = 26'd0;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e == 2) begin
                cfg_we   = 1'b1;
                cfg_ch   = 3'd5;
                cfg_half = 26'd2;
            end else begin
                cfg_we = 1'b0;
            end
            tests_run++;
            if (cfg_err !== exp_err[e-1]) begin
                tests_failed++;
                $display("FAIL cfg_err edge %0d: got %b, expected %b", e, cfg_err, exp_err[e-1]);
            end
        end
        check_vec("reject_state", 4, 4'hF, 4'hF);
        for (int e = 5; e <= 8; e++) step();
        check_vec("reject_state", 8, 4'h0, 4'hF);
    endtask

    task automatic test_half_one();
        do_reset();
        enable   = 4'hF;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_half = 26'd1;
        step();
        cfg_we = 1'b0;
        check_vec("half1_load", 1, 4'h0, 4'h0);
        for (int e = 2; e <= 7; e++) begin
            step();
            check_vec("half1", e,
                      {(e >= 4) ? 3'b111 : 3'b000, (e % 2 == 0) ? 1'b1 : 1'b0},
                      {(e == 4) ? 3'b111 : 3'b000, 1'b1});
        end
    endtask

    task automatic test_write_at_terminal();
        do_reset();
        enable = 4'hF;
        step();
        step();
        step();
        cfg_we   = 1'b1;
        cfg_ch   = 3'd2;
        cfg_half = 26'd3;
        step();
        cfg_we = 1'b0;
        check_vec("write_terminal", 4, 4'b1011, 4'b1011);
        step();
        step();
        check_vec("write_terminal", 6, 4'b1011, 4'b0000);
        step();
        check_vec("write_terminal", 7, 4'b1111, 4'b0100);
    endtask

    task automatic test_sync();
        do_reset();
        enable = 4'b0001;
        step();
        enable = 4'b0011;
        step();
        enable = 4'b0111;
        step();
        enable = 4'b1111;
        step();
        check_vec("stagger", 4, 4'b0001, 4'b0001);
        step();
        check_vec("stagger", 5, 4'b0011, 4'b0010);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_vec("sync_edge", 6, 4'h0, 4'h0);
        for (int e = 7; e <= 10; e++) begin
            step();
            check_vec("after_sync", e, (e == 10) ? 4'hF : 4'h0, (e == 10) ? 4'hF : 4'h0);
        end
    endtask

    task automatic test_disable_and_reset();
        do_reset();
        enable   = 4'hF;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_half = 26'd2;
        step();
        cfg_we = 1'b0;
        for (int e = 2; e <= 5; e++) step();
        enable = 4'b1011;
        step();
        check_vec("disable_ch2", 6, 4'b1010, 4'b0000);
        step();
        check_vec("disable_ch2", 7, 4'b1011, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: clk_out=%b tick=%b cfg_err=%b, expected 0000 0000 0",
                     clk_out, tick, cfg_err);
        end
        step();
        rst_n  = 1'b1;
        enable = 4'hF;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_vec("half_restored", e, (e == 4) ? 4'hF : 4'h0, (e == 4) ? 4'hF : 4'h0);
        end
    endtask

    initial begin
        test_reset();
        test_write_mid_period();
        test_reject();
        test_half_one();
        test_write_at_terminal();
        test_sync();
        test_disable_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
